uart_prog_loader: RTL
=====================

Name: uart_prog_loader

Overview:
- Boot-time program loader upstream of the instruction RAM.
- Consumes a byte stream from a UART receiver and assembles little-endian 32-bit words. Writes each word into instruction memory through the same request/address/w_en/write_data/masking interface that memory already accepts.
- Holds the core in reset until a complete image has been received and its checksum verified.

Parameters:
- ADDR_W, 8, word-address width of the instruction RAM
- MAX_WORDS, 256, largest accepted image length in words; must be ≤ 2**ADDR_W
- TIMEOUT_CYC, 1000000, maximum idle cycles between bytes once a frame has started

Ports:
- clk  input  1  system clock; all logic on rising edge
- rst  input  1  reset, synchronous, active-low
- rx_valid  input  1  one-cycle strobe: rx_data holds a received byte
- rx_data  input  8  received byte
- request  output  1  memory access request, one-cycle pulse per word
- w_en  output  1  write enable, equal to request
- address  output  ADDR_W  word address of the write
- write_data  output  32  assembled word
- masking  output  4  byte lanes; 4'b1111 whenever w_en=1, else 4'b0000
- core_rst  output  1  active-low reset to the core; 0 until load succeeds
- done  output  1  image loaded and verified (sticky)
- error  output  1  frame rejected (sticky)

Behaviour:
- Reset (rst=0 at a clock edge) values:
  - request=0, w_en=0, address=0, write_data=0, masking=0
  - core_rst=0, done=0, error=0
  - state=LEN; byte counter, word counter, length register, checksum and timeout counter all cleared.
- Reset mid-load aborts the load. The next frame restarts at address 0.
- Frame format:
  - 4 length bytes, LSB first, giving N words.
  - 4·N data bytes; each word is LSB first.
  - 1 checksum byte equal to the XOR of all 4·N data bytes. Length bytes are excluded.
- States:
  - LEN: collect 4 bytes. After the 4th byte:
    - N=0 -> CSUM
    - N>MAX_WORDS -> ERR
    - otherwise -> DATA
  - DATA:
    - Each byte is shifted into assembly register byte lane [byte_cnt] and XORed into the checksum.
    - On the 4th byte of a word, the cycle after that byte is accepted has request=w_en=1, masking=4'b1111, address=word_cnt, write_data=assembled word, for exactly one cycle.
    - word_cnt then increments. When word_cnt reaches N -> CSUM.
  - CSUM: one byte.
    - Equal to checksum -> DONE.
    - Otherwise -> ERR.
  - DONE: done=1 and core_rst=1 from the cycle after the checksum byte. All further rx bytes are ignored; no writes occur. Exit only by reset.
  - ERR: error=1, core_rst stays 0, no writes occur. Exit only by reset.
- The assembly register is separate from the write_data output register, so a byte arriving in the write-pulse cycle is accepted without loss. Write latency is 1 cycle after the 4th byte.
- Timeout:
  - The counter is cleared on every accepted byte and increments every cycle while a frame is in progress. In progress means at least one byte has been received and state is LEN, DATA or CSUM.
  - Reaching TIMEOUT_CYC -> ERR.
  - In LEN before the first byte there is no timeout; the loader waits indefinitely.
- Address never wraps, because N ≤ MAX_WORDS ≤ 2**ADDR_W.
- rx_valid is sampled only in LEN, DATA and CSUM.

Decomposition:
- Shared package holds:
  - state encoding constants: LEN, DATA, CSUM, DONE, ERR
  - MASK_ALL = 4'b1111
  - frame constant LEN_BYTES = 4
- Natural sub-module: loader_word_asm.
  - Contains the byte-lane counter, the 32-bit assembly shift register and the running XOR checksum.
  - Outputs a word_ready strobe.
  - Cleared by the parent on reset.
- The FSM, word counter and timeout stay in uart_prog_loader.

Test Plan:
- Happy path:
  - Stimulus: bytes 02 00 00 00 | 13 00 00 00 | 6F 00 00 00 | csum 7C.
  - Response: writes (addr 0, 0x00000013) then (addr 1, 0x0000006F), each a 1-cycle request with masking F; then done=1, core_rst=1, error=0.
- Zero length:
  - Stimulus: 00 00 00 00 then 00.
  - Response: no writes; done=1 the cycle after the checksum byte.
- Bad checksum:
  - Stimulus: the happy-path frame with checksum 7D.
  - Response: both writes occur; error=1, core_rst=0, done=0.
- Oversize:
  - Stimulus: length 01 01 00 00 (257).
  - Response: error=1 after the 4th byte; no writes issued.
- Timeout and reset recovery:
  - Stimulus: send 3 bytes, then idle TIMEOUT_CYC cycles. Then pulse rst=0 for one cycle and send the happy-path frame.
  - Response: error=1 after the idle period; after reset, normal load at addresses 0 and 1.
- Back-to-back and post-done:
  - Stimulus: rx_valid asserted on consecutive cycles across a word boundary.
  - Response: no byte lost; data correct.
  - Stimulus: extra bytes after done.
  - Response: ignored, no request pulses.

Source files
------------

// File: rtl/uart_prog_loader_pkg.sv
// Shared types and constants for the UART program loader.
package uart_prog_loader_pkg;

  // Loader frame states
  typedef enum logic [2:0] {
    StLen,
    StData,
    StCsum,
    StDone,
    StErr
  } state_e;

  // All four byte lanes enabled for a full-word write
  localparam logic [3:0] MASK_ALL = 4'b1111;

  // Bytes in the length header and in each data word
  localparam int unsigned LEN_BYTES = 4;

endpackage

// File: rtl/uart_prog_loader_word_asm.sv
// Assembles little-endian 32-bit words from a byte stream and keeps a running XOR checksum.
module uart_prog_loader_word_asm
  import uart_prog_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        valid,
  input  logic [7:0]  data,
  output logic [31:0] word,
  output logic        word_ready,
  output logic [7:0]  csum
);

  logic [1:0]  lane_q;
  logic [23:0] asm_q;
  logic [7:0]  csum_q;

  // The top lane is taken straight from the incoming byte, so the word is
  // available in the same cycle its last byte is accepted.
  always_comb begin
    word_ready = valid && (lane_q == 2'(LEN_BYTES - 1));
    word       = {data, asm_q};
    csum       = csum_q;
  end

  // Byte-lane counter, shift register and checksum accumulate on each valid byte
  always_ff @(posedge clk) begin
    if (!rst) begin
      lane_q <= 2'd0;
      asm_q  <= 24'd0;
      csum_q <= 8'd0;
    end else if (valid) begin
      lane_q <= lane_q + 2'd1;
      asm_q  <= {data, asm_q[23:8]};
      csum_q <= csum_q ^ data;
    end
  end

endmodule

// File: rtl/uart_prog_loader.sv
// Boot-time loader: receives a length-prefixed, checksummed image over UART,
// writes it into instruction RAM and releases the core once verified.
module uart_prog_loader
  import uart_prog_loader_pkg::*;
#(
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned MAX_WORDS   = 256,
  parameter int unsigned TIMEOUT_CYC = 1000000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              request,
  output logic              w_en,
  output logic [ADDR_W-1:0] address,
  output logic [31:0]       write_data,
  output logic [3:0]        masking,
  output logic              core_rst,
  output logic              done,
  output logic              error
);

  // One extra bit so the word counter can hold N == 2**ADDR_W
  localparam int unsigned CNT_W = ADDR_W + 1;

  state_e            state_q, state_d;
  logic [1:0]        len_byte_q, len_byte_d;
  logic [23:0]       len_shift_q, len_shift_d;
  logic [CNT_W-1:0]  len_words_q, len_words_d;
  logic [CNT_W-1:0]  word_cnt_q, word_cnt_d;
  logic [31:0]       tmo_q, tmo_d;
  logic              started_q, started_d;
  logic              req_q, req_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;

  logic              active;
  logic              accept;
  logic              asm_valid;
  logic [31:0]       asm_word;
  logic              word_ready;
  logic [7:0]        csum;
  logic [31:0]       full_len;
  logic [CNT_W-1:0]  word_cnt_inc;

  uart_prog_loader_word_asm u_word_asm (
    .clk        (clk),
    .rst        (rst),
    .valid      (asm_valid),
    .data       (rx_data),
    .word       (asm_word),
    .word_ready (word_ready),
    .csum       (csum)
  );

  // Next-state, header decode, word write and timeout logic
  always_comb begin
    state_d     = state_q;
    len_byte_d  = len_byte_q;
    len_shift_d = len_shift_q;
    len_words_d = len_words_q;
    word_cnt_d  = word_cnt_q;
    tmo_d       = tmo_q;
    started_d   = started_q;
    req_d       = 1'b0;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    asm_valid   = 1'b0;

    active       = (state_q == StLen) || (state_q == StData) || (state_q == StCsum);
    accept       = active && rx_valid;
    full_len     = {rx_data, len_shift_q};
    word_cnt_inc = word_cnt_q + CNT_W'(1);

    if (accept) begin
      tmo_d     = 32'd0;
      started_d = 1'b1;
    end else if (active && started_q) begin
      tmo_d = tmo_q + 32'd1;
    end

    unique case (state_q)
      StLen: begin
        if (rx_valid) begin
          if (len_byte_q == 2'(LEN_BYTES - 1)) begin
            len_words_d = full_len[CNT_W-1:0];
            if (full_len == 32'd0) begin
              state_d = StCsum;
            end else if (full_len > MAX_WORDS) begin
              state_d = StErr;
            end else begin
              state_d = StData;
            end
          end else begin
            len_shift_d = {rx_data, len_shift_q[23:8]};
            len_byte_d  = len_byte_q + 2'd1;
          end
        end
      end
      StData: begin
        if (rx_valid) begin
          asm_valid = 1'b1;
          if (word_ready) begin
            req_d      = 1'b1;
            addr_d     = word_cnt_q[ADDR_W-1:0];
            wdata_d    = asm_word;
            word_cnt_d = word_cnt_inc;
            if (word_cnt_inc == len_words_q) begin
              state_d = StCsum;
            end
          end
        end
      end
      StCsum: begin
        if (rx_valid) begin
          state_d = (rx_data == csum) ? StDone : StErr;
        end
      end
      default: ;
    endcase

    // A stalled frame is abandoned; tmo_d is zero whenever a byte was accepted
    if (active && (tmo_d == TIMEOUT_CYC)) begin
      state_d = StErr;
    end
  end

  // State and datapath registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= StLen;
      len_byte_q  <= 2'd0;
      len_shift_q <= 24'd0;
      len_words_q <= '0;
      word_cnt_q  <= '0;
      tmo_q       <= 32'd0;
      started_q   <= 1'b0;
      req_q       <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= 32'd0;
    end else begin
      state_q     <= state_d;
      len_byte_q  <= len_byte_d;
      len_shift_q <= len_shift_d;
      len_words_q <= len_words_d;
      word_cnt_q  <= word_cnt_d;
      tmo_q       <= tmo_d;
      started_q   <= started_d;
      req_q       <= req_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
    end
  end

  // Memory-port and status outputs
  always_comb begin
    request    = req_q;
    w_en       = req_q;
    address    = addr_q;
    write_data = wdata_q;
    masking    = req_q ? MASK_ALL : 4'b0000;
    done       = (state_q == StDone);
    core_rst   = (state_q == StDone);
    error      = (state_q == StErr);
  end

endmodule
